rv32i_instr_encoder: RTL

RV32I_INSTR_ENCODER -- requirements
Module: rv32i_instr_encoder

---
 rtl/rv32i_pkg.sv | 59 +++++
 rtl/enc_fifo.sv | 62 ++++++
 rtl/rv32i_instr_encoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I encoder/decoder types, opcodes and word builder
// Contents:
//   enc_op_t     command opcode selector driven on cmd_op
//   OPC_*        7-bit major opcodes, also used by the decoder side
//   enc_state_t  load-session FSM states
//   enc_word()   builds one instruction word from command fields (immediates truncated)
package rv32i_pkg;

  typedef enum logic [2:0] {
    OP_R   = 3'd0,
    OP_I   = 3'd1,
    OP_LW  = 3'd2,
    OP_SW  = 3'd3,
    OP_BEQ = 3'd4,
    OP_BNE = 3'd5,
    OP_JAL = 3'd6
  } enc_op_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

  function automatic logic [31:0] enc_word(
    input enc_op_t     op,
    input logic [2:0]  funct3,
    input logic        funct7_5,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (op)
      OP_R:   w = {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, OPC_R};
      // Shift-right immediates carry the arithmetic/logical select in bit 30.
      OP_I:   if (funct3 == 3'b101) w = {1'b0, funct7_5, 5'b0, imm[4:0], rs1, funct3, rd, OPC_I};
              else                  w = {imm[11:0], rs1, funct3, rd, OPC_I};
      OP_LW:  w = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      OP_SW:  w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      OP_BEQ,
      OP_BNE: w = {imm[12], imm[10:5], rs2, rs1, 2'b00, (op == OP_BNE), imm[4:1], imm[11], OPC_BRANCH};
      OP_JAL: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// rtl/enc_fifo.sv - small synchronous FIFO holding encoded instruction words
// Ports:
//   clk, reset       clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata      write one word when not full
//   pop, rdata       rdata is the head entry; pop removes it when not empty
//   full, empty      occupancy flags
//   count            current occupancy
module enc_fifo #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [31:0]                     wdata,
  input  logic                            pop,
  output logic [31:0]                     rdata,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - encodes RV32I commands and streams them into instruction memory
// Optional feature macro: ENC_RANGE_CHECK_EN (immediate range checking, drives err).
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start, base_addr            open a load session at base_addr (IDLE only)
//   cmd_valid, cmd_ready        command handshake; cmd_op/cmd_funct3/cmd_funct7_5/cmd_rd/
//                               cmd_rs1/cmd_rs2/cmd_imm/cmd_last are the command fields
//   imem_we, imem_addr,         memory write, held until imem_ack
//   imem_wdata, imem_ack
//   busy, done, word_count, err session status (done is a one-cycle pulse, err is sticky)
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int MAX_WORDS  = 256,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                base_addr,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  enc_op_t                    cmd_op,
  input  logic [2:0]                 cmd_funct3,
  input  logic                       cmd_funct7_5,
  input  logic [4:0]                 cmd_rd,
  input  logic [4:0]                 cmd_rs1,
  input  logic [4:0]                 cmd_rs2,
  input  logic [31:0]                cmd_imm,
  input  logic                       cmd_last,
  output logic                       imem_we,
  output logic [31:0]                imem_addr,
  output logic [31:0]                imem_wdata,
  input  logic                       imem_ack,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(MAX_WORDS):0] word_count,
  output logic                       err
);

  localparam int WC_W = $clog2(MAX_WORDS) + 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  enc_state_t    state;
  enc_state_t    state_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   head_data;
  logic [31:0]   enc_data;
  logic          accept;
  logic          push;
  logic          pop;
  logic          imm_ok;
  logic          budget_hit;
  logic [WC_W:0] occupied;

  // Words already written plus words still queued; this is what the budget limits.
  assign occupied   = {1'b0, word_count} + (WC_W+1)'(fifo_count);
  assign budget_hit = (occupied + (WC_W+1)'(push)) >= (WC_W+1)'(MAX_WORDS);

  assign enc_data   = enc_word(cmd_op, cmd_funct3, cmd_funct7_5, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && imm_ok;
  assign imem_we    = !fifo_empty;
  assign imem_wdata = imem_we ? head_data : '0;
  assign pop        = imem_we && imem_ack;

`ifdef ENC_RANGE_CHECK_EN
  function automatic logic imm_fits(input enc_op_t op, input logic [31:0] imm);
    case (op)
      OP_I, OP_LW, OP_SW: return imm[31:11] == {21{imm[11]}};
      OP_BEQ, OP_BNE:     return (imm[31:12] == {20{imm[12]}}) && !imm[0];
      OP_JAL:             return (imm[31:20] == {12{imm[20]}}) && !imm[0];
      default:            return 1'b1;
    endcase
  endfunction

  logic err_q;
  assign imm_ok = imm_fits(cmd_op, cmd_imm);
  assign err    = err_q;

  // Out-of-range commands are consumed but dropped; err remembers it until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_q <= 1'b0;
    else if (state == ST_IDLE && start) err_q <= 1'b0;
    else if (accept && !imm_ok)         err_q <= 1'b1;
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^cmd_imm[31:21];
  assign imm_ok        = 1'b1;
  assign err           = 1'b0;
`endif

  enc_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (enc_data),
    .pop   (pop),
    .rdata (head_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && (cmd_last || budget_hit)) state_nxt = ST_DRAIN;
      // imem_we is derived from FIFO occupancy, so empty means nothing is pending.
      ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_LOAD: begin
        busy      = 1'b1;
        cmd_ready = !fifo_full && (occupied < (WC_W+1)'(MAX_WORDS));
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_addr  <= '0;
      word_count <= '0;
    end else if (state == ST_IDLE && start) begin
      imem_addr  <= base_addr;
      word_count <= '0;
    end else if (pop) begin
      imem_addr  <= imem_addr + 32'd4;
      word_count <= word_count + WC_W'(1);
    end
  end

endmodule
